// File: rtl/apb_slv_pkg.sv
// Shared types and width helpers for the APB4 completer memory.
package apb_slv_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int STRB_WIDTH     = DEF_DATA_WIDTH / 8;
  localparam int ADDR_LSB       = $clog2(STRB_WIDTH);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  // Kept as a named reason so coverage can bin error causes separately.
  typedef enum logic [1:0] {
    OK,
    OUT_OF_RANGE,
    MISALIGNED
  } err_e;

  function automatic int strb_width(input int dw);
    return dw / 8;
  endfunction

  function automatic int addr_lsb(input int dw);
    return (dw > 8) ? $clog2(dw / 8) : 0;
  endfunction

endpackage

// File: rtl/apb_slv_mem.sv
// Byte-enabled word storage: async clear, one write port, one combinational read port.
module apb_slv_mem
  import apb_slv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = 64,
  parameter int IDX_W      = 6
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH/8-1:0]   wr_strb,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic [DATA_WIDTH-1:0]     rd_data
);

  localparam int SW = strb_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < SW; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer over a word-organised register memory.
// Optional wait states are enabled with `define APB_SLV_WAIT_EN (WAIT_CYCLES per transfer).
//
//   state  | meaning
//   IDLE   | waiting for SETUP (PSELx=1, PENABLE=0); bus request latched on exit
//   ACCESS | counting wait states, then completing with PREADY=1
module apb_slave_mem
  import apb_slv_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSELx,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int LSB   = addr_lsb(DATA_WIDTH);
  localparam int WIDX  = ADDR_WIDTH - LSB;
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [WIDX:0] DEPTH_L = (WIDX + 1)'(MEM_DEPTH);

  if (!(DATA_WIDTH inside {8, 16, 32, 64}) || WAIT_CYCLES < 0) begin : g_bad_param
    $error("apb_slave_mem: illegal DATA_WIDTH or WAIT_CYCLES");
  end

  state_e                  state;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic                    lat_write;
  logic [DATA_WIDTH-1:0]   lat_wdata;
  logic [DATA_WIDTH/8-1:0] lat_strb;
  logic                    cnt_zero;
  logic                    misaligned;
  logic                    out_of_range;
  logic                    err;
  logic                    wr_en;
  logic [WIDX-1:0]         word_idx;
  logic [IDX_W-1:0]        mem_idx;
  logic [DATA_WIDTH-1:0]   rd_data;
  err_e                    err_reason;

`ifdef APB_SLV_WAIT_EN
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] wait_cnt;
  assign cnt_zero = (wait_cnt == '0);
`else
  assign cnt_zero = 1'b1;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
      lat_strb  <= '0;
`ifdef APB_SLV_WAIT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // PENABLE=1 without a SETUP is ignored: we simply never leave IDLE.
          if (PSELx && !PENABLE) begin
            lat_addr  <= PADDR;
            lat_write <= PWRITE;
            lat_wdata <= PWDATA;
            lat_strb  <= PSTRB;
`ifdef APB_SLV_WAIT_EN
            wait_cnt  <= CNT_W'(WAIT_CYCLES);
`endif
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (!PSELx) begin
            state <= IDLE;
          end else if (PENABLE) begin
            if (cnt_zero) begin
              state <= IDLE;
            end
`ifdef APB_SLV_WAIT_EN
            else begin
              wait_cnt <= wait_cnt - 1'b1;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign word_idx = lat_addr[ADDR_WIDTH-1:LSB];
  assign mem_idx  = word_idx[IDX_W-1:0];

  if (LSB > 0) begin : g_align
    assign misaligned = (lat_addr[LSB-1:0] != '0);
  end else begin : g_no_align
    assign misaligned = 1'b0;
  end

  assign out_of_range = ({1'b0, word_idx} >= DEPTH_L);

  always_comb begin
    err_reason = OK;
    if (misaligned) begin
      err_reason = MISALIGNED;
    end else if (out_of_range) begin
      err_reason = OUT_OF_RANGE;
    end
  end

  assign err = (err_reason != OK);

  // Gated by PSELx/PENABLE so an aborted or malformed ACCESS never signals completion.
  assign PREADY  = (state == ACCESS) && PSELx && PENABLE && cnt_zero;
  assign PSLVERR = PREADY && err;
  assign PRDATA  = (PREADY && !err && !lat_write) ? rd_data : '0;
  assign wr_en   = PREADY && !err && lat_write;

  apb_slv_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .wr_en   (wr_en),
    .wr_idx  (mem_idx),
    .wr_data (lat_wdata),
    .wr_strb (lat_strb),
    .rd_idx  (mem_idx),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem; follows APB_SLV_WAIT_EN for expected latency.
module tb_apb_slave_mem;

  localparam int AW = 10;
  localparam int DW = 32;
`ifdef APB_SLV_WAIT_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          PSELx;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [3:0]    PSTRB;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int n_tests = 0;
  int n_fail  = 0;

  apb_slave_mem #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .MEM_DEPTH   (64),
    .WAIT_CYCLES (2)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSELx   (PSELx),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full transfer; waits = PREADY-low ACCESS cycles seen before completion.
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [3:0] strb, output logic [DW-1:0] rdata,
                      output logic slverr, output int waits);
    bit done = 0;
    rdata = '0;
    slverr = 1'b0;
    waits = 0;
    @(posedge PCLK); #1;
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    PADDR = ~addr;
    PWDATA = ~wdata;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge PCLK);
      if (PREADY) begin
        rdata = PRDATA;
        slverr = PSLVERR;
        done = 1;
      end else begin
        waits++;
      end
    end
    if (!done) chk("xfer_timeout", 64'd0, 64'd1);
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0;
  endtask

  logic [DW-1:0] rd;
  logic          er;
  int            w;

  initial begin
    PRESET = 1'b1; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_pready", 64'(PREADY), 64'd0);
    chk("rst_pslverr", 64'(PSLVERR), 64'd0);
    chk("rst_prdata", 64'(PRDATA), 64'd0);
    PRESET = 1'b0;

    xfer(1'b1, 10'h004, 32'hDEADBEEF, 4'hF, rd, er, w);
    chk("wr04_err", 64'(er), 64'd0);
    chk("wr04_waits", 64'(w), 64'(EXP_WAIT));
    xfer(1'b0, 10'h004, 32'h0, 4'h0, rd, er, w);
    chk("rd04_data", 64'(rd), 64'hDEADBEEF);
    chk("rd04_err", 64'(er), 64'd0);

    xfer(1'b1, 10'h008, 32'h5A5A5A5A, 4'hF, rd, er, w);
    chk("wr08_waits", 64'(w), 64'(EXP_WAIT));
    chk("wr08_total_cycles", 64'(w + 2), 64'(EXP_WAIT + 2));
    xfer(1'b0, 10'h008, 32'h0, 4'h0, rd, er, w);
    chk("rd08_data", 64'(rd), 64'h5A5A5A5A);

    xfer(1'b1, 10'h00C, 32'h11223344, 4'hF, rd, er, w);
    xfer(1'b1, 10'h00C, 32'hAABBCCDD, 4'b0101, rd, er, w);
    xfer(1'b0, 10'h00C, 32'h0, 4'h0, rd, er, w);
    chk("rd0c_strb", 64'(rd), 64'h11BB33DD);
    xfer(1'b1, 10'h00C, 32'hFFFFFFFF, 4'h0, rd, er, w);
    chk("wr0c_nostrb_err", 64'(er), 64'd0);
    xfer(1'b0, 10'h00C, 32'h0, 4'h0, rd, er, w);
    chk("rd0c_nostrb", 64'(rd), 64'h11BB33DD);

    xfer(1'b1, 10'h0FC, 32'hCAFEF00D, 4'hF, rd, er, w);
    chk("wr_fc_err", 64'(er), 64'd0);
    xfer(1'b0, 10'h0FC, 32'h0, 4'h0, rd, er, w);
    chk("rd_fc_data", 64'(rd), 64'hCAFEF00D);

    xfer(1'b0, 10'h100, 32'h0, 4'h0, rd, er, w);
    chk("rd100_err", 64'(er), 64'd1);
    chk("rd100_data", 64'(rd), 64'd0);
    xfer(1'b1, 10'h100, 32'h12345678, 4'hF, rd, er, w);
    chk("wr100_err", 64'(er), 64'd1);
    xfer(1'b1, 10'h002, 32'h87654321, 4'hF, rd, er, w);
    chk("wr02_err", 64'(er), 64'd1);
    chk("wr02_prdata", 64'(rd), 64'd0);
    xfer(1'b0, 10'h000, 32'h0, 4'h0, rd, er, w);
    chk("rd00_unchanged", 64'(rd), 64'd0);
    chk("rd00_err", 64'(er), 64'd0);
    xfer(1'b0, 10'h005, 32'h0, 4'h0, rd, er, w);
    chk("rd05_misalign_err", 64'(er), 64'd1);
    chk("rd05_misalign_data", 64'(rd), 64'd0);

    // Reset in the ACCESS phase of a write to 0x10.
    @(posedge PCLK); #1;
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 10'h010; PWDATA = 32'h99887766; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2 PRESET = 1'b1;
    #1;
    chk("midrst_pready", 64'(PREADY), 64'd0);
    chk("midrst_pslverr", 64'(PSLVERR), 64'd0);
    chk("midrst_prdata", 64'(PRDATA), 64'd0);
    PSELx = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    xfer(1'b0, 10'h010, 32'h0, 4'h0, rd, er, w);
    chk("rd10_after_rst", 64'(rd), 64'd0);
    xfer(1'b0, 10'h004, 32'h0, 4'h0, rd, er, w);
    chk("rd04_after_rst", 64'(rd), 64'd0);

    // Abort in ACCESS, then PENABLE without SETUP.
    @(posedge PCLK); #1;
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 10'h014; PWDATA = 32'h13579BDF; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b1;
    @(negedge PCLK);
    chk("abort_pready", 64'(PREADY), 64'd0);
    @(posedge PCLK); #1;
    PSELx = 1'b1; PENABLE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk($sformatf("nosetup_pready%0d", i), 64'(PREADY), 64'd0);
    end
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0;
    xfer(1'b0, 10'h014, 32'h0, 4'h0, rd, er, w);
    chk("rd14_no_write", 64'(rd), 64'd0);
    chk("rd14_waits_idle_ok", 64'(w), 64'(EXP_WAIT));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
